// File: rtl/cpld_romsel_map.sv
// Upper-ROM select mapper: decodes the ROM-select and config IO ports and drives socket chip selects.
// Latency: selections and table writes take effect one wclk after the IO write strobe ends; outputs are combinational.
// Backpressure: none; every IO write is accepted. Ports: wclk/reset_b, adr/ioreq_b/wr_b/data (CPU), romen_b,
//   dip_en/dip_mode (switches); rom_cs_b/roma14/romoe_b/romdis (ROM socket control).
module cpld_romsel_map #(
   parameter int         NSOCK  = 3,
   parameter logic [7:0] CFG_LO = 8'hF0
) (
   input  logic                 wclk,
   input  logic                 reset_b,
   input  logic [15:0]          adr,
   input  logic                 ioreq_b,
   input  logic                 wr_b,
   input  logic                 romen_b,
   input  logic [7:0]           data,
   input  logic [2*NSOCK-1:0]   dip_en,
   input  logic [1:0]           dip_mode,
   output logic [NSOCK-1:0]     rom_cs_b,
   output logic                 roma14,
   output logic                 romoe_b,
   output logic                 romdis
);

   localparam int NSLOT = 2*NSOCK;

   typedef enum logic [1:0] {IDLE, KEY1, INDEX, VALUE} cfg_state_t;

   // Power-on ROM number for slot k under each switch-selected map.
   // In modes 00/01 slot 0 is the lower ROM, so its map entry is never compared.
   function automatic logic [7:0] dflt_map(input logic [1:0] mode, input int k);
      logic [7:0] kb;
      kb = 8'(k);
      case (mode)
         2'b00:   return (k == 0) ? 8'h00 : kb - 8'd1;
         2'b01:   return (k == 0) ? 8'h00 : ((k == 1) ? 8'h01 : kb + 8'd8);
         2'b10:   return kb + 8'd1;
         default: return kb + 8'd8;
      endcase
   endfunction

   logic             selwr, cfgwr;
   logic             selwr_q, cfgwr_q;
   logic             sel_commit, cfg_commit;
   logic [7:0]       data_q;
   logic [7:0]       romsel_q;
   cfg_state_t       state_q, state_d;
   logic [6:0]       idx_q, idx_d;
   logic             pend_q, pend_d;
   logic             map_wr, reload;
   logic [7:0]       map_q [NSLOT];
   logic [NSLOT-1:0] ena_q;
   logic [NSLOT-1:0] hit;
   logic             found;
   logic             unused_adr;

   assign unused_adr = ^adr[9:8];

   // The two decodes are disjoint (adr[15:13] = 110 vs 111).
   assign selwr = !ioreq_b && !wr_b && (adr[15:13] == 3'b110);
   assign cfgwr = !ioreq_b && !wr_b && (adr[15:10] == 6'b111110) && (adr[7:0] == CFG_LO);

   // Act once per IO cycle, on the falling edge of the registered strobe,
   // using the data captured during the last strobe cycle.
   assign sel_commit = selwr_q && !selwr;
   assign cfg_commit = cfgwr_q && !cfgwr;

   always_ff @(posedge wclk or negedge reset_b) begin
      if (!reset_b) begin
         selwr_q  <= 1'b0;
         cfgwr_q  <= 1'b0;
         data_q   <= 8'h00;
         romsel_q <= 8'h00;
         state_q  <= IDLE;
         idx_q    <= 7'd0;
         pend_q   <= 1'b0;
      end else begin
         selwr_q <= selwr;
         cfgwr_q <= cfgwr;
         if (selwr || cfgwr)
            data_q <= data;
         if (sel_commit)
            romsel_q <= data_q;
         state_q <= state_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
      end
   end

   // Config unlock sequence: 52, 4F, index, value.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pend_d  = pend_q;
      map_wr  = 1'b0;
      reload  = 1'b0;
      if (cfg_commit) begin
         case (state_q)
            IDLE:  state_d = (data_q == 8'h52) ? KEY1 : IDLE;
            KEY1:  state_d = (data_q == 8'h4F) ? INDEX : IDLE;
            INDEX: begin
               state_d = IDLE;
               if (data_q == 8'h7F) begin
                  reload = 1'b1;
               end else if (data_q[6:0] < 7'(NSLOT)) begin
                  idx_d   = data_q[6:0];
                  pend_d  = data_q[7];
                  state_d = VALUE;
               end
            end
            VALUE: begin
               map_wr  = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Reset reloads defaults from whatever dip_mode shows while reset is held.
   always_ff @(posedge wclk or negedge reset_b) begin
      if (!reset_b) begin
         for (int i = 0; i < NSLOT; i++) begin
            map_q[i] <= dflt_map(dip_mode, i);
            ena_q[i] <= 1'b1;
         end
      end else if (reload) begin
         for (int i = 0; i < NSLOT; i++) begin
            map_q[i] <= dflt_map(dip_mode, i);
            ena_q[i] <= 1'b1;
         end
      end else if (map_wr) begin
         for (int i = 0; i < NSLOT; i++) begin
            if (idx_q == 7'(i)) begin
               map_q[i] <= data_q;
               ena_q[i] <= !pend_q;
            end
         end
      end
   end

   always_comb begin
      hit = '0;
      for (int i = 0; i < NSLOT; i++) begin
         if (i == 0 && !dip_mode[1])
            hit[i] = !adr[14] && dip_en[i] && ena_q[i];
         else
            hit[i] = adr[14] && dip_en[i] && ena_q[i] && (map_q[i] == romsel_q);
      end
   end

   // Lowest-numbered hitting slot owns the bus.
   always_comb begin
      rom_cs_b = '1;
      roma14   = 1'b0;
      found    = 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
         if (hit[i] && !found) begin
            found  = 1'b1;
            roma14 = 1'(i % 2);
            for (int k = 0; k < NSOCK; k++) begin
               if (k == i / 2)
                  rom_cs_b[k] = 1'b0;
            end
         end
      end
   end

   assign romdis  = found;
   assign romoe_b = romen_b;

endmodule

// File: tb/tb_cpld_romsel_map.sv
module tb_cpld_romsel_map;

   localparam int NSOCK = 3;
   localparam int NSLOT = 6;
   localparam logic [15:0] SEL_ADR = 16'hDF00;
   localparam logic [15:0] CFG_ADR = 16'hFBF0;

   logic              wclk, reset_b, ioreq_b, wr_b, romen_b;
   logic [15:0]       adr;
   logic [7:0]        data;
   logic [NSLOT-1:0]  dip_en;
   logic [1:0]        dip_mode;
   logic [NSOCK-1:0]  rom_cs_b;
   logic              roma14, romoe_b, romdis;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;
   bit rd_a14 = 1;

   // Transaction-level model of the mapper state.
   int m_map [NSLOT];
   bit m_ena [NSLOT];
   int m_romsel;
   int m_phase;      // bytes of the 52,4F,index,value sequence accepted so far
   int m_idx;
   bit m_dis;

   cpld_romsel_map #(.NSOCK(NSOCK), .CFG_LO(8'hF0)) dut (
      .wclk(wclk), .reset_b(reset_b), .adr(adr), .ioreq_b(ioreq_b), .wr_b(wr_b),
      .romen_b(romen_b), .data(data), .dip_en(dip_en), .dip_mode(dip_mode),
      .rom_cs_b(rom_cs_b), .roma14(roma14), .romoe_b(romoe_b), .romdis(romdis)
   );

   initial wclk = 0;
   always #5 wclk = ~wclk;

   function automatic int dflt(input logic [1:0] mode, input int k);
      case (mode)
         2'b00:   return (k == 0) ? 0 : k - 1;
         2'b01:   return (k == 0) ? 0 : ((k == 1) ? 1 : k + 8);
         2'b10:   return k + 1;
         default: return k + 8;
      endcase
   endfunction

   task automatic model_defaults(input logic [1:0] mode);
      for (int k = 0; k < NSLOT; k++) begin
         m_map[k] = dflt(mode, k);
         m_ena[k] = 1;
      end
   endtask

   task automatic model_apply(input logic [15:0] a, input logic [7:0] d);
      if (a[15:13] == 3'b110) begin
         m_romsel = int'(d);
      end else if (a[15:10] == 6'b111110 && a[7:0] == 8'hF0) begin
         case (m_phase)
            0: m_phase = (d == 8'h52) ? 1 : 0;
            1: m_phase = (d == 8'h4F) ? 2 : 0;
            2: begin
               m_phase = 0;
               if (d == 8'h7F) model_defaults(dip_mode);
               else if (int'(d[6:0]) < NSLOT) begin
                  m_idx = int'(d[6:0]); m_dis = d[7]; m_phase = 3;
               end
            end
            default: begin
               m_map[m_idx] = int'(d);
               m_ena[m_idx] = !m_dis;
               m_phase = 0;
            end
         endcase
      end
   endtask

   task automatic model_expect(output logic [NSOCK-1:0] cs, output logic a14, output logic dis);
      int win;
      bit h;
      win = -1;
      for (int i = 0; i < NSLOT; i++) begin
         if (win < 0) begin
            if (i == 0 && dip_mode[1] == 1'b0)
               h = !adr[14] && dip_en[i] && m_ena[i];
            else
               h = adr[14] && dip_en[i] && m_ena[i] && (m_map[i] == m_romsel);
            if (h) win = i;
         end
      end
      cs  = '1;
      a14 = 0;
      dis = (win >= 0);
      if (win >= 0) begin
         cs[win / 2] = 1'b0;
         a14 = (win % 2 == 1);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge wclk) begin
      logic [NSOCK-1:0] ecs;
      logic ea14, edis;
      if (chk_en && reset_b) begin
         model_expect(ecs, ea14, edis);
         checks++;
         if (rom_cs_b !== ecs || romdis !== edis || (edis && roma14 !== ea14) || romoe_b !== romen_b) begin
            errors++;
            $display("FAIL model t=%0t: cs=%b a14=%b dis=%b oe=%b, expected cs=%b a14=%b dis=%b oe=%b",
                     $time, rom_cs_b, roma14, romdis, romoe_b, ecs, ea14, edis, romen_b);
         end
      end
   end

   task automatic check_lit(input string name, input logic [NSOCK-1:0] cs, input logic a14, input logic dis);
      @(negedge wclk);
      checks++;
      if (rom_cs_b !== cs || romdis !== dis || (dis && roma14 !== a14)) begin
         errors++;
         $display("FAIL %s: cs=%b a14=%b dis=%b, expected cs=%b a14=%b dis=%b",
                  name, rom_cs_b, roma14, romdis, cs, a14, dis);
      end
   endtask

   task automatic set_rd(input bit a14);
      @(posedge wclk); #1;
      rd_a14 = a14;
      adr = a14 ? 16'h4000 : 16'h0000;
   endtask

   task automatic io_wr(input logic [15:0] a, input logic [7:0] d);
      @(posedge wclk); #1;
      adr = a; data = d; ioreq_b = 0; wr_b = 0;
      @(posedge wclk); #1;
      @(posedge wclk); #1;
      ioreq_b = 1; wr_b = 1; data = 8'h00;
      adr = rd_a14 ? 16'h4000 : 16'h0000;
      @(posedge wclk); #1;
      model_apply(a, d);
   endtask

   task automatic sel_wr(input logic [7:0] d);
      io_wr(SEL_ADR, d);
   endtask

   task automatic cfg_seq(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
      io_wr(CFG_ADR, b0); io_wr(CFG_ADR, b1); io_wr(CFG_ADR, b2); io_wr(CFG_ADR, b3);
   endtask

   task automatic do_reset(input logic [1:0] mode);
      @(posedge wclk); #1;
      dip_mode = mode;
      reset_b = 0;
      m_romsel = 0; m_phase = 0; m_idx = 0; m_dis = 0;
      model_defaults(mode);
      @(posedge wclk); #1;
      @(posedge wclk); #1;
      reset_b = 1;
   endtask

   initial begin
      reset_b = 0; ioreq_b = 1; wr_b = 1; romen_b = 1; data = 0;
      adr = 16'h4000; dip_en = '1; dip_mode = 2'b00;
      do_reset(2'b00);
      chk_en = 1;

      // Mode 00 after reset
      check_lit("rst_slot1", 3'b110, 1'b1, 1'b1);
      set_rd(0);
      check_lit("m00_slot0_lower", 3'b110, 1'b0, 1'b1);
      romen_b = 0;
      @(negedge wclk);
      checks++;
      if (romoe_b !== 1'b0) begin
         errors++;
         $display("FAIL romoe: got %b, expected 0", romoe_b);
      end
      romen_b = 1;
      set_rd(1);
      sel_wr(8'd7);
      check_lit("m00_rs7_none", 3'b111, 1'b0, 1'b0);

      // Table programming
      cfg_seq(8'h52, 8'h4F, 8'h02, 8'h07);
      check_lit("prog_slot2", 3'b101, 1'b0, 1'b1);
      cfg_seq(8'h52, 8'h4F, 8'h82, 8'h07);
      check_lit("dis_slot2", 3'b111, 1'b0, 1'b0);
      io_wr(CFG_ADR, 8'h52);
      cfg_seq(8'h11, 8'h4F, 8'h02, 8'h07);
      check_lit("bad_key", 3'b111, 1'b0, 1'b0);
      cfg_seq(8'h52, 8'h4F, 8'h06, 8'h07);
      check_lit("idx_range", 3'b111, 1'b0, 1'b0);

      // A romsel write in the middle of the unlock sequence
      io_wr(CFG_ADR, 8'h52);
      sel_wr(8'd0);
      io_wr(CFG_ADR, 8'h4F); io_wr(CFG_ADR, 8'h02); io_wr(CFG_ADR, 8'h07);
      check_lit("sel_mid_rs0_slot1", 3'b110, 1'b1, 1'b1);
      sel_wr(8'd7);
      check_lit("sel_mid_slot2", 3'b101, 1'b0, 1'b1);
      dip_en = 6'b111011;
      check_lit("dipen_slot2_off", 3'b111, 1'b0, 1'b0);
      dip_en = '1;

      // Mode 01 defaults
      do_reset(2'b01);
      sel_wr(8'd1);
      check_lit("m01_slot1", 3'b110, 1'b1, 1'b1);
      sel_wr(8'd10);
      check_lit("m01_slot2", 3'b101, 1'b0, 1'b1);

      // Mode 10 defaults, priority, reload
      do_reset(2'b10);
      sel_wr(8'd4);
      check_lit("m10_slot3", 3'b101, 1'b1, 1'b1);
      dip_mode = 2'b11;
      check_lit("mode_chg_keep", 3'b101, 1'b1, 1'b1);
      dip_mode = 2'b10;
      cfg_seq(8'h52, 8'h4F, 8'h04, 8'h03);
      sel_wr(8'd3);
      check_lit("prio_slot2", 3'b101, 1'b0, 1'b1);
      sel_wr(8'd5);
      check_lit("slot4_reprog", 3'b111, 1'b0, 1'b0);
      dip_mode = 2'b11;
      io_wr(CFG_ADR, 8'h52); io_wr(CFG_ADR, 8'h4F); io_wr(CFG_ADR, 8'h7F);
      sel_wr(8'd9);
      check_lit("reload_m11", 3'b110, 1'b1, 1'b1);
      dip_mode = 2'b10;
      io_wr(CFG_ADR, 8'h52); io_wr(CFG_ADR, 8'h4F); io_wr(CFG_ADR, 8'h7F);
      sel_wr(8'd5);
      check_lit("reload_m10_slot4", 3'b011, 1'b0, 1'b1);

      // Reset between key and index
      do_reset(2'b00);
      io_wr(CFG_ADR, 8'h52); io_wr(CFG_ADR, 8'h4F);
      do_reset(2'b00);
      io_wr(CFG_ADR, 8'h02); io_wr(CFG_ADR, 8'h07);
      sel_wr(8'd7);
      check_lit("rst_mid_seq", 3'b111, 1'b0, 1'b0);
      cfg_seq(8'h52, 8'h4F, 8'h02, 8'h07);
      check_lit("after_rst_prog", 3'b101, 1'b0, 1'b1);

      repeat (2) @(posedge wclk);
      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
